multilane_addr_gen: RTL and testbench

Parametrised multi-lane address generator for the matrix-multiply memory path. It emits LANES consecutive word addresses per beat, starting at a run-time base, for a run-time word count. Beats are handed to the consumer over a valid/ready handshake. A partial final beat is supported and flagged by a per-lane enable mask. It replaces the fixed 8-lane, fixed-window address counters feeding the 128x128 operand and result buffers.

---
 rtl/multilane_addr_gen.sv | 118 +++++++++++
 tb/tb_multilane_addr_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multilane_addr_gen.sv
// multilane_addr_gen
// Emits LANES consecutive word addresses per beat, starting at a run-time base,
// for a run-time word count, over a valid/ready handshake.
// All state advances on the falling edge of clk. The partial final beat is
// marked through lane_en. The outputs are a pure decode of state, cur and rem,
// so ready only steers the next state.
module multilane_addr_gen #(
  parameter int ADDR_W = 14,
  parameter int LANES  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         cfg_base,
  input  logic [ADDR_W:0]           cfg_count,
  input  logic                      ready,
  output logic [LANES*ADDR_W-1:0]   addr,
  output logic [LANES-1:0]          lane_en,
  output logic                      valid,
  output logic                      last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LANES_REM  = (ADDR_W+1)'(LANES);
  localparam logic [ADDR_W-1:0] LANES_ADDR = ADDR_W'(LANES);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   cur_r;
  logic [ADDR_W:0]     rem_r;
  logic                start_ok_s;
  logic                xfer_s;
  logic                last_s;

  // A start only counts while idle or done. A beat moves when RUN meets ready.
  // The beat is final once no more than one beat's worth of words remains.
  assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign xfer_s     = (state_r == RUN) && ready;
  assign last_s     = (rem_r <= LANES_REM);

  // State register, with synchronous active-low reset on the falling edge
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: launch, finish on the last transfer, ignore start in RUN
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = (cfg_count != {(ADDR_W+1){1'b0}}) ? RUN : DONE;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (ready && last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Address and word-count datapath. cur stays on the last beat when the run ends.
  always_ff @(negedge clk) begin
    if (!reset) begin
      cur_r <= {ADDR_W{1'b0}};
      rem_r <= {(ADDR_W+1){1'b0}};
    end else if (start_ok_s) begin
      cur_r <= cfg_base;
      rem_r <= cfg_count;
    end else if (xfer_s) begin
      if (last_s) begin
        rem_r <= {(ADDR_W+1){1'b0}};
      end else begin
        cur_r <= cur_r + LANES_ADDR;
        rem_r <= rem_r - LANES_REM;
      end
    end else begin
      cur_r <= cur_r;
      rem_r <= rem_r;
    end
  end

  // Output decode. IDLE is reached only through reset, so addr reads zero there.
  always_comb begin
    addr    = {(LANES*ADDR_W){1'b0}};
    lane_en = {LANES{1'b0}};
    valid   = (state_r == RUN);
    busy    = (state_r == RUN);
    done    = (state_r == DONE);
    last    = (state_r == RUN) && last_s;
    for (int i = 0; i < LANES; i++) begin
      if (state_r == IDLE) begin
        addr[i*ADDR_W +: ADDR_W] = {ADDR_W{1'b0}};
      end else begin
        addr[i*ADDR_W +: ADDR_W] = cur_r + ADDR_W'(i);
      end
      lane_en[i] = (state_r == RUN) && ((ADDR_W+1)'(i) < rem_r);
    end
  end

endmodule

// File: tb/tb_multilane_addr_gen.sv
// Bench for multilane_addr_gen. A beat-index model predicts every output from
// base, count and beat number. The DUT changes state on the falling edge, so
// outputs are checked on the rising edge and inputs are driven 1 ns after it.
module tb_multilane_addr_gen;

  localparam int AW = 14;
  localparam int LN = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [AW-1:0]     cfg_base;
  logic [AW:0]       cfg_count;
  logic              ready;
  logic [LN*AW-1:0]  addr;
  logic [LN-1:0]     lane_en;
  logic              valid;
  logic              last;
  logic              busy;
  logic              done;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  multilane_addr_gen #(.ADDR_W(AW), .LANES(LN)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .ready(ready), .addr(addr), .lane_en(lane_en),
    .valid(valid), .last(last), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [AW-1:0] lane(input int i);
    return addr[i*AW +: AW];
  endfunction

  // Behavioural model. The phase is 0 for idle, 1 for run and 2 for done.
  // k is the index of the current beat.
  int m_phase = 0;
  int m_base  = 0;
  int m_count = 0;
  int m_k     = 0;

  function automatic int nbeats();
    return (m_count + LN - 1) / LN;
  endfunction

  function automatic logic [LN*AW-1:0] exp_addr();
    logic [LN*AW-1:0] v;
    v = '0;
    if (m_phase != 0)
      for (int i = 0; i < LN; i++) v[i*AW +: AW] = AW'(m_base + m_k*LN + i);
    return v;
  endfunction

  function automatic logic [LN-1:0] exp_lane_en();
    logic [LN-1:0] v;
    int left;
    v = '0;
    left = m_count - m_k*LN;
    if (m_phase == 1)
      for (int i = 0; i < LN; i++) v[i] = (i < left);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      m_phase <= 0; m_base <= 0; m_count <= 0; m_k <= 0;
    end else if (m_phase == 1) begin
      if (ready) begin
        if (m_k == nbeats() - 1) m_phase <= 2;
        else m_k <= m_k + 1;
      end
    end else if (start) begin
      m_base  <= int'(cfg_base);
      m_count <= int'(cfg_count);
      m_k     <= 0;
      m_phase <= (cfg_count != '0) ? 1 : 2;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    if (chk_en) begin
      chk("addr",    256'(addr),    256'(exp_addr()));
      chk("lane_en", 256'(lane_en), 256'(exp_lane_en()));
      chk("valid",   256'(valid),   256'(m_phase == 1));
      chk("busy",    256'(busy),    256'(m_phase == 1));
      chk("done",    256'(done),    256'(m_phase == 2));
      chk("last",    256'(last),    256'((m_phase == 1) && (m_k == nbeats() - 1)));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] c);
    cfg_base = b; cfg_count = c; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    logic [LN*AW-1:0] hold_addr;
    logic [LN-1:0]    hold_en;
    logic [31:0]      r;
    int nx;
    int nb;
    int pat [5] = '{1, 0, 0, 1, 1};

    reset = 1'b0; start = 1'b0; cfg_base = '0; cfg_count = '0; ready = 1'b0;
    tick; tick; tick;
    chk_en = 1'b1;
    chk("rst_valid",   256'(valid),   256'(1'b0));
    chk("rst_done",    256'(done),    256'(1'b0));
    chk("rst_addr",    256'(addr),    256'(0));
    chk("rst_lane_en", 256'(lane_en), 256'(0));
    reset = 1'b1;
    tick;

    // Partial final beat
    ready = 1'b1;
    start_run(14'h0100, 15'd13);
    chk("p1_lane0", 256'(lane(0)), 256'(14'h0100));
    chk("p1_lane7", 256'(lane(7)), 256'(14'h0107));
    chk("p1_en",    256'(lane_en),  256'(8'hFF));
    chk("p1_last",  256'(last),     256'(1'b0));
    tick;
    chk("p2_lane0", 256'(lane(0)), 256'(14'h0108));
    chk("p2_lane7", 256'(lane(7)), 256'(14'h010F));
    chk("p2_en",    256'(lane_en),  256'(8'h1F));
    chk("p2_last",  256'(last),     256'(1'b1));
    tick;
    chk("p_done",   256'(done),  256'(1'b1));
    chk("p_busy",   256'(busy),  256'(1'b0));
    tick;
    chk("p_done_held", 256'(done), 256'(1'b1));

    // Back-pressure with ready pattern 1,0,0,1,1
    start_run(14'h0200, 15'd24);
    nx = 0;
    for (int p = 0; p < 5; p++) begin
      ready = pat[p][0];
      hold_addr = addr; hold_en = lane_en;
      if (valid && ready) nx++;
      tick;
      if (pat[p] == 0) begin
        chk("bp_addr_stable", 256'(addr),    256'(hold_addr));
        chk("bp_en_stable",   256'(lane_en), 256'(hold_en));
      end
    end
    chk("bp_xfers", 256'(nx),   256'(3));
    chk("bp_done",  256'(done), 256'(1'b1));

    // Wrap within one beat, then a zero-count run
    ready = 1'b1;
    start_run(14'h3FFC, 15'd8);
    chk("w_lane0", 256'(lane(0)), 256'(14'h3FFC));
    chk("w_lane3", 256'(lane(3)), 256'(14'h3FFF));
    chk("w_lane4", 256'(lane(4)), 256'(14'h0000));
    chk("w_lane7", 256'(lane(7)), 256'(14'h0003));
    chk("w_last",  256'(last),    256'(1'b1));
    tick;
    chk("w_done",  256'(done),    256'(1'b1));
    start_run(14'h0040, 15'd0);
    chk("z_done", 256'(done), 256'(1'b1));
    for (int c = 0; c < 3; c++) begin
      chk("z_valid", 256'(valid), 256'(1'b0));
      tick;
    end

    // Full window of 4096 words
    start_run(14'h2000, 15'd4096);
    chk("f_lane0", 256'(lane(0)), 256'(14'h2000));
    chk("f_lane7", 256'(lane(7)), 256'(14'h2007));
    nb = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (valid) begin
        nb++;
        if (last) begin
          chk("f_last_lane0", 256'(lane(0)), 256'(14'h2FF8));
          chk("f_last_lane7", 256'(lane(7)), 256'(14'h2FFF));
        end
      end
      tick;
    end
    chk("f_beats", 256'(nb),   256'(512));
    chk("f_done",  256'(done), 256'(1'b1));

    // start ignored mid-run, then reset at beat 3 of a 10-beat run
    start_run(14'h1000, 15'd80);
    cfg_base = 14'h0555; cfg_count = 15'd5; start = 1'b1;
    tick;
    start = 1'b0;
    chk("s_lane0", 256'(lane(0)), 256'(14'h1008));
    chk("s_busy",  256'(busy),    256'(1'b1));
    tick;
    chk("s_beat3", 256'(lane(0)), 256'(14'h1010));
    reset = 1'b0;
    tick;
    chk("r_addr",  256'(addr),    256'(0));
    chk("r_en",    256'(lane_en), 256'(0));
    chk("r_valid", 256'(valid),   256'(1'b0));
    chk("r_busy",  256'(busy),    256'(1'b0));
    chk("r_done",  256'(done),    256'(1'b0));
    reset = 1'b1;
    tick;
    start_run(14'h0777, 15'd10);
    chk("n_lane0", 256'(lane(0)), 256'(14'h0777));
    chk("n_en1",   256'(lane_en), 256'(8'hFF));
    tick;
    chk("n_lane0b", 256'(lane(0)), 256'(14'h077F));
    chk("n_en2",    256'(lane_en),  256'(8'h03));
    chk("n_last",   256'(last),     256'(1'b1));
    tick;

    // Randomized traffic, checked every cycle by the model comparison
    for (int it = 0; it < 400; it++) begin
      r = $urandom;
      cfg_base = r[AW-1:0];
      case ($urandom_range(0, 3))
        0:       cfg_count = 15'd0;
        1:       cfg_count = 15'($urandom_range(1, 8));
        2:       cfg_count = 15'(8 * $urandom_range(1, 6));
        default: cfg_count = 15'($urandom_range(1, 70));
      endcase
      start = ($urandom_range(0, 5) == 0);
      ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 63) != 0);
      tick;
    end
    reset = 1'b1; start = 1'b0; ready = 1'b1;
    tick; tick;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
